// File: rtl/m_s_ff_pkg.sv
// Shared constants for the master-slave register slice.
package m_s_ff_pkg;

  localparam int unsigned MSFF_DEF_WIDTH = 8;

endpackage

// File: rtl/ms_latch.sv
// Transparent-high level latch with asynchronous active-high reset to RESET_VAL.
module ms_latch
  import m_s_ff_pkg::*;
#(
  parameter int unsigned           WIDTH     = MSFF_DEF_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             i_en,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_latch begin
    if (i_rst) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/m_s_ff.sv
// Master-slave D register bank acting as a positive-edge flop with async reset.
// Optional MSFF_HOLD_EN adds a hold input that recirculates q into the master.
module m_s_ff
  import m_s_ff_pkg::*;
#(
  parameter int unsigned      WIDTH     = MSFF_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef MSFF_HOLD_EN
  ,
  input  logic             hold
`endif
);

  logic             w_clk_n;
  logic [WIDTH-1:0] w_master_d;
  logic [WIDTH-1:0] w_master_q;

  assign w_clk_n = ~clk;

  // Hold reloads the master from the slave so the next edge re-captures q.
`ifdef MSFF_HOLD_EN
  assign w_master_d = hold ? q : d;
`else
  assign w_master_d = d;
`endif

  ms_latch #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_master (
    .i_en  (w_clk_n),
    .i_rst (reset),
    .i_d   (w_master_d),
    .o_q   (w_master_q)
  );

  ms_latch #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_slave (
    .i_en  (clk),
    .i_rst (reset),
    .i_d   (w_master_q),
    .o_q   (q)
  );

endmodule

// File: tb/tb_m_s_ff.sv
// Self-checking bench for m_s_ff: directed timing sequences, a vector table and
// randomized traffic against an edge-level reference model.
module tb_m_s_ff;

  localparam logic [18:0] RV19 = 19'd0;
  localparam logic [11:0] RV12 = 12'hABC;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        hold  = 1'b0;
  logic [18:0] d19   = '0;
  logic [11:0] d12   = '0;
  logic [18:0] q19;
  logic [11:0] q12;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

`ifdef MSFF_HOLD_EN
  m_s_ff #(.WIDTH(19), .RESET_VAL(RV19)) u_w19 (.clk(clk), .reset(reset), .d(d19), .q(q19), .hold(hold));
  m_s_ff #(.WIDTH(12), .RESET_VAL(RV12)) u_w12 (.clk(clk), .reset(reset), .d(d12), .q(q12), .hold(hold));
`else
  m_s_ff #(.WIDTH(19), .RESET_VAL(RV19)) u_w19 (.clk(clk), .reset(reset), .d(d19), .q(q19));
  m_s_ff #(.WIDTH(12), .RESET_VAL(RV12)) u_w12 (.clk(clk), .reset(reset), .d(d12), .q(q12));
`endif

  // Reference model: value seen at the last rising edge, reset value while reset is high.
  logic [18:0] exp19 = RV19;
  logic [11:0] exp12 = RV12;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp19 = RV19;
      exp12 = RV12;
    end else begin
`ifdef MSFF_HOLD_EN
      if (!hold) begin
        exp19 = d19;
        exp12 = d12;
      end
`else
      exp19 = d19;
      exp12 = d12;
`endif
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic wait_until(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  typedef struct {
    logic        rst;
    logic [18:0] d19;
    logic [11:0] d12;
    logic [18:0] e19;
    logic [11:0] e12;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Rising edges at 10, 30, 50, ...; clk is high over [10+20k, 20+20k).
    d19 = 19'd110;
    d12 = 12'd0;
    wait_until(3);
    chk("reset_q19_low", 64'(q19), 64'(RV19));
    chk("reset_q12_low", 64'(q12), 64'(RV12));
    wait_until(12);
    chk("reset_q19_high", 64'(q19), 64'(RV19));
    wait_until(15);
    reset = 1'b0;
    wait_until(25);
    chk("post_release_no_edge", 64'(q19), 64'(RV19));
    wait_until(35);
    chk("first_capture_q19", 64'(q19), 64'd110);
    chk("first_capture_q12", 64'(q12), 64'd0);

    // d changes while clk high: no effect until next rising edge.
    wait_until(36);
    d19 = 19'd12400;
    wait_until(38);
    chk("d_change_high", 64'(q19), 64'd110);
    wait_until(45);
    chk("d_change_low", 64'(q19), 64'd110);
    wait_until(55);
    chk("d_change_captured", 64'(q19), 64'd12400);

    // Reset pulse in the low phase.
    wait_until(62);
    reset = 1'b1;
    wait_until(63);
    chk("midlow_reset_q19", 64'(q19), 64'(RV19));
    chk("midlow_reset_q12", 64'(q12), 64'(RV12));
    wait_until(82);
    reset = 1'b0;
    wait_until(85);
    chk("midlow_release_hold", 64'(q19), 64'(RV19));
    wait_until(95);
    chk("midlow_recapture_q19", 64'(q19), 64'd12400);
    chk("midlow_recapture_q12", 64'(q12), 64'd0);

    // Several d toggles inside one low phase; only the last one is captured.
    wait_until(101);
    d12 = 12'd1;
    wait_until(102);
    chk("toggle_q12_a", 64'(q12), 64'd0);
    wait_until(103);
    d12 = 12'hFFF;
    wait_until(104);
    chk("toggle_q12_b", 64'(q12), 64'd0);
    wait_until(105);
    d12 = 12'h555;
    wait_until(107);
    d12 = 12'd72;
    wait_until(108);
    chk("toggle_q12_c", 64'(q12), 64'd0);
    wait_until(115);
    chk("toggle_final", 64'(q12), 64'd72);

    // Reset asserted while clk high: immediate, no edge required.
    wait_until(132);
    reset = 1'b1;
    wait_until(133);
    chk("highphase_reset_q12", 64'(q12), 64'(RV12));
    chk("highphase_reset_q19", 64'(q19), 64'(RV19));
    wait_until(145);
    reset = 1'b0;
    wait_until(155);
    chk("highphase_recapture_q12", 64'(q12), 64'd72);
    chk("highphase_recapture_q19", 64'(q19), 64'd12400);

    // Vector table: applied in the low phase, checked after the following edge.
    tbl[0] = '{1'b0, 19'd1,       12'd1,     19'd1,       12'd1};
    tbl[1] = '{1'b0, 19'h7FFFF,   12'hFFF,   19'h7FFFF,   12'hFFF};
    tbl[2] = '{1'b0, 19'd0,       12'd0,     19'd0,       12'd0};
    tbl[3] = '{1'b0, 19'h40000,   12'h800,   19'h40000,   12'h800};
    tbl[4] = '{1'b1, 19'd5,       12'd5,     RV19,        RV12};
    tbl[5] = '{1'b0, 19'd6,       12'd6,     19'd6,       12'd6};
    tbl[6] = '{1'b0, 19'h2AAAA,   12'h555,   19'h2AAAA,   12'h555};
    tbl[7] = '{1'b1, 19'h55555,   12'hAAA,   RV19,        RV12};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      reset = tbl[i].rst;
      d19   = tbl[i].d19;
      d12   = tbl[i].d12;
      @(posedge clk);
      #5;
      chk($sformatf("tbl%0d_q19", i), 64'(q19), 64'(tbl[i].e19));
      chk($sformatf("tbl%0d_q12", i), 64'(q12), 64'(tbl[i].e12));
    end
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Randomized traffic against the reference model, checked in both phases.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      reset = ($urandom_range(15) == 0);
      d19   = 19'($urandom);
      d12   = 12'($urandom);
      #1;
      chk("rnd_low_q19", 64'(q19), 64'(exp19));
      chk("rnd_low_q12", 64'(q12), 64'(exp12));
      @(posedge clk);
      #5;
      chk("rnd_high_q19", 64'(q19), 64'(exp19));
      chk("rnd_high_q12", 64'(q12), 64'(exp12));
    end
    @(negedge clk);
    #2;
    reset = 1'b0;

`ifdef MSFF_HOLD_EN
    // Hold keeps q across edges; release captures d; reset overrides hold.
    d19 = 19'd5;
    d12 = 12'd5;
    @(posedge clk);
    #5;
    chk("hold_load", 64'(q19), 64'd5);
    @(negedge clk);
    #2;
    hold = 1'b1;
    d19  = 19'd9;
    d12  = 12'd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #5;
      chk("hold_q19", 64'(q19), 64'd5);
      chk("hold_q12", 64'(q12), 64'd5);
    end
    @(negedge clk);
    #2;
    hold = 1'b0;
    @(posedge clk);
    #5;
    chk("hold_release", 64'(q19), 64'd9);
    @(negedge clk);
    #2;
    hold  = 1'b1;
    reset = 1'b1;
    #1;
    chk("hold_reset_q19", 64'(q19), 64'(RV19));
    chk("hold_reset_q12", 64'(q12), 64'(RV12));
    @(negedge clk);
    #2;
    reset = 1'b0;
    hold  = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
